snn_spike_aer_enc: RTL and testbench
====================================

SNN_SPIKE_AER_ENC -- requirements
Module: snn_spike_aer_enc

Interface
REQ-001 Parameter N, default 96: width of the spike vector; it matches the core neuron count.
REQ-002 Parameter TS_W, default 16: width of the timestep stamp.
REQ-003 Parameter AW, default $clog2(N): width of the neuron address.
REQ-004 Parameter DC_W, default 16: width of the drop counter.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rstn  in  1  reset; asynchronous assert, active-low.
REQ-007 in_valid  in  1  spike vector present this clock; asserted once per timestep by the core stage.
REQ-008 in_spikes  in  N  spikes_vec from the core; bit n = neuron n fired.
REQ-009 in_ready  out  1  encoder can latch a vector this clock.
REQ-010 aer_valid  out  1  address event valid.
REQ-011 aer_ready  in  1  downstream accepts the event.
REQ-012 aer_addr  out  AW  index of the firing neuron.
REQ-013 aer_ts  out  TS_W  timestep stamp of the vector the event came from.
REQ-014 aer_last  out  1  event is the final spike of its timestep.
REQ-015 step_done  out  1  one-clock pulse when a timestep is fully emitted or was empty.
REQ-016 ovf  out  1  sticky flag: at least one vector was dropped.
REQ-017 drop_cnt  out  DC_W  count of dropped vectors.
REQ-018 clr_ovf  in  1  synchronous clear of ovf and drop_cnt.

Function
REQ-019 The encoder SHALL have two states: IDLE and SCAN.
REQ-020 in_ready SHALL equal 1 exactly when the state is IDLE.
REQ-021 A timestep counter ts_cnt (TS_W bits) SHALL increment by 1 on every clock with in_valid=1, whether the vector is accepted or dropped.
- ts_cnt wraps modulo 2^TS_W.
REQ-022 Accept (IDLE, in_valid=1): latch in_spikes into the pending mask and the current ts_cnt into ts_reg.
- Nonzero vector: go to SCAN.
- Zero vector: stay in IDLE, pulse step_done the next clock, emit no event.
REQ-023 In SCAN:
- aer_valid=1.
- aer_addr = index of the lowest set bit of the pending mask.
- aer_ts = ts_reg.
- aer_last=1 iff exactly one bit is set.
REQ-024 aer_addr, aer_ts and aer_last SHALL hold stable while aer_valid=1 and aer_ready=0.
REQ-025 On aer_valid and aer_ready:
- Clear the emitted bit.
- If aer_last=1, return to IDLE and pulse step_done the next clock.
REQ-026 Events SHALL be emitted in ascending neuron index; throughput is 1 event/clk with aer_ready held high.
REQ-027 Latency: vector accepted at clock k gives its first aer_valid at clock k+1; a k-spike vector finishes at clock k+k_spikes at the earliest.
REQ-028 Drop (in_valid=1 while in SCAN): discard the vector, set ovf, and increment drop_cnt.
- drop_cnt saturates at 2^DC_W-1.
REQ-029 clr_ovf and a drop in the same clock: the clear wins for ovf; drop_cnt loads 1 and ovf is set the following cycle only if another drop occurs.
REQ-030 A vector arriving on the same clock as the final handshake SHALL be dropped, because in_ready=0 in SCAN.
REQ-031 aer_valid SHALL be 0 in IDLE; aer_addr/aer_ts/aer_last are don't-care there but driven to 0.

Reset
REQ-032 On rstn=0:
- Go to IDLE.
- Pending mask, ts_cnt, ts_reg, drop_cnt = 0.
- ovf, step_done, aer_valid = 0.
- in_ready = 1 immediately after deassertion.
REQ-033 Reset asserted mid-SCAN SHALL abandon the remaining events with no further aer_valid; after release, ts_cnt restarts at 0.

Structure
REQ-034 Package snn_aer_pkg SHALL hold the state enum aer_state_t {IDLE, SCAN} and a default addr-width constant.
REQ-035 The lowest-set-bit search SHALL be the sub-module snn_prio_enc, parameter N; outputs idx[AW], any, onehot_single.
REQ-036 The block SHALL sit directly after the core, with in_spikes wired to spikes_vec and in_valid driven by the core step strobe.

Verification
REQ-037 Reset, then a vector with bits {3,17,95}, aer_ready=1 -> events at k+1..k+3: addr 3,17,95; ts=0; aer_last only on 95; step_done at k+4.
REQ-038 Zero vector accepted -> no aer_valid, step_done one clock later, ts_cnt advances to 1.
REQ-039 Bits {5,6}, aer_ready low 4 clocks then high -> addr 5 held stable 4 clocks, then 5, 6 in order.
REQ-040 All 96 bits set, two more in_valid during SCAN -> 96 events 0..95; drop_cnt=2, ovf=1; the next vector is stamped ts=3.
REQ-041 Force drop_cnt near 2^16-1 with repeated drops -> drop_cnt saturates at 65535; clr_ovf then gives ovf=0, drop_cnt=0.
REQ-042 rstn low mid-SCAN of {0..10} after 3 events -> aer_valid=0 during reset; post-reset vector {7} emits addr 7, ts=0.

Source files
------------

// File: rtl/snn_spike_aer_enc_pkg.sv
// -----------------------------------------------------------------------------
// snn_aer_pkg
// Shared types and constants for the spike-vector to AER encoder.
//   aer_state_t    : encoder state (IDLE waits for a vector, SCAN emits events)
//   AER_AW_DEFAULT : default neuron address width (96 neurons -> 7 bits)
// -----------------------------------------------------------------------------
package snn_aer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } aer_state_t;

    localparam int AER_AW_DEFAULT = 7;

endpackage

// File: rtl/snn_prio_enc.sv
// -----------------------------------------------------------------------------
// snn_prio_enc
// Combinational lowest-set-bit finder over an N-bit mask.
//   vec           in  N   mask to search
//   idx           out AW  index of the lowest set bit (0 when vec is zero)
//   any           out 1   at least one bit of vec is set
//   onehot_single out 1   exactly one bit of vec is set
// -----------------------------------------------------------------------------
module snn_prio_enc
    import snn_aer_pkg::*;
#(
    parameter int N  = 96,
    parameter int AW = AER_AW_DEFAULT
) (
    input  logic [N-1:0]  vec,
    output logic [AW-1:0] idx,
    output logic          any,
    output logic          onehot_single
);

    logic [N-1:0] w_vec_minus1;

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = AW'(i);
            end
        end
    end

    // v & (v-1) clears the lowest set bit; zero afterwards means a single bit.
    assign w_vec_minus1  = vec - {{(N-1){1'b0}}, 1'b1};
    assign any           = |vec;
    assign onehot_single = any && ((vec & w_vec_minus1) == '0);

endmodule

// File: rtl/snn_spike_aer_enc.sv
// -----------------------------------------------------------------------------
// snn_spike_aer_enc
// Converts one spike vector per timestep from the neuron core into a stream of
// address events, lowest neuron index first, each stamped with its timestep.
//   clk, rstn       clock, asynchronous active-low reset
//   in_valid        in   core step strobe; a spike vector is present
//   in_spikes[N]    in   spikes_vec from the core, bit n = neuron n fired
//   in_ready        out  encoder is IDLE and will latch a vector
//   aer_valid       out  address event valid
//   aer_ready       in   downstream accepts the event
//   aer_addr[AW]    out  firing neuron index
//   aer_ts[TS_W]    out  timestep stamp of the source vector
//   aer_last        out  final event of its timestep
//   step_done       out  one-clock pulse: timestep fully emitted or empty
//   ovf             out  sticky: a vector arrived while busy and was dropped
//   drop_cnt[DC_W]  out  saturating count of dropped vectors
//   clr_ovf         in   synchronous clear of ovf and drop_cnt
// -----------------------------------------------------------------------------
module snn_spike_aer_enc
    import snn_aer_pkg::*;
#(
    parameter int N    = 96,
    parameter int TS_W = 16,
    parameter int AW   = $clog2(N),
    parameter int DC_W = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [N-1:0]    in_spikes,
    output logic            in_ready,
    output logic            aer_valid,
    input  logic            aer_ready,
    output logic [AW-1:0]   aer_addr,
    output logic [TS_W-1:0] aer_ts,
    output logic            aer_last,
    output logic            step_done,
    output logic            ovf,
    output logic [DC_W-1:0] drop_cnt,
    input  logic            clr_ovf
);

    aer_state_t      r_state;
    logic [N-1:0]    r_pend;
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_reg;
    logic            r_step_done;
    logic            r_ovf;
    logic [DC_W-1:0] r_drop_cnt;

    logic [AW-1:0]   w_idx;
    logic            w_any;
    logic            w_single;
    logic            w_scan;
    logic            w_drop;
    logic            w_fire;

    snn_prio_enc #(
        .N  (N),
        .AW (AW)
    ) u_prio (
        .vec           (r_pend),
        .idx           (w_idx),
        .any           (w_any),
        .onehot_single (w_single)
    );

    assign w_scan = (r_state == SCAN);
    assign w_drop = in_valid && w_scan;
    assign w_fire = w_scan && w_any && aer_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_ts_cnt    <= '0;
            r_ts_reg    <= '0;
            r_step_done <= 1'b0;
            r_ovf       <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_step_done <= 1'b0;

            // Every step strobe advances time, accepted or dropped.
            if (in_valid) begin
                r_ts_cnt <= r_ts_cnt + TS_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pend   <= in_spikes;
                        r_ts_reg <= r_ts_cnt;
                        if (|in_spikes) begin
                            r_state <= SCAN;
                        end else begin
                            r_step_done <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (w_fire) begin
                        // Clear the lowest set bit, i.e. the event just taken.
                        r_pend <= r_pend & (r_pend - {{(N-1){1'b0}}, 1'b1});
                        if (w_single) begin
                            r_state     <= IDLE;
                            r_step_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A clear in the same clock as a drop keeps ovf low but still
            // counts that drop.
            if (clr_ovf) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= w_drop ? DC_W'(1) : '0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != {DC_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + DC_W'(1);
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign aer_valid = w_scan && w_any;
    assign aer_addr  = aer_valid ? w_idx    : '0;
    assign aer_ts    = aer_valid ? r_ts_reg : '0;
    assign aer_last  = aer_valid ? w_single : 1'b0;
    assign step_done = r_step_done;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_snn_spike_aer_enc.sv
// -----------------------------------------------------------------------------
// tb_snn_spike_aer_enc
// Directed bench for snn_spike_aer_enc with N=96, TS_W=16, DC_W=16.
// Inputs change 1 time unit after the rising edge; outputs are observed at
// that same point, so every observation shows the state left by that edge.
// -----------------------------------------------------------------------------
module tb_snn_spike_aer_enc;

    localparam int N    = 96;
    localparam int TS_W = 16;
    localparam int AW   = 7;
    localparam int DC_W = 16;

    logic            clk;
    logic            rstn;
    logic            in_valid;
    logic [N-1:0]    in_spikes;
    logic            in_ready;
    logic            aer_valid;
    logic            aer_ready;
    logic [AW-1:0]   aer_addr;
    logic [TS_W-1:0] aer_ts;
    logic            aer_last;
    logic            step_done;
    logic            ovf;
    logic [DC_W-1:0] drop_cnt;
    logic            clr_ovf;

    int checks;
    int errors;

    snn_spike_aer_enc #(
        .N    (N),
        .TS_W (TS_W),
        .AW   (AW),
        .DC_W (DC_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_spikes (in_spikes),
        .in_ready  (in_ready),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
        .aer_ts    (aer_ts),
        .aer_last  (aer_last),
        .step_done (step_done),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_spikes = '0;
        aer_ready = 1'b1;
        clr_ovf   = 1'b0;
        step();
        step();
        rstn = 1'b1;
        #1;
    endtask

    // Reset values, and in_ready right after release.
    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_spikes = '0;
        aer_ready = 1'b0;
        clr_ovf   = 1'b0;
        step();
        step();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL rst_aer_valid got=%b exp=0", aer_valid); end
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL rst_step_done got=%b exp=0", step_done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (aer_addr !== 7'd0 || aer_ts !== 16'd0 || aer_last !== 1'b0) begin errors++; $display("FAIL rst_aer_fields got=%0d/%0d/%b exp=0/0/0", aer_addr, aer_ts, aer_last); end
        rstn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    // Bits {3,17,95} with ready high: three back-to-back events, ts=0.
    task automatic test_basic();
        logic [AW-1:0] exp_addr [3];
        exp_addr[0] = 7'd3; exp_addr[1] = 7'd17; exp_addr[2] = 7'd95;
        aer_ready = 1'b1;
        in_spikes = '0;
        in_spikes[3] = 1'b1; in_spikes[17] = 1'b1; in_spikes[95] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_scan got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aer_valid !== 1'b1 || aer_addr !== exp_addr[i] || aer_ts !== 16'd0 || aer_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_event%0d got v=%b a=%0d ts=%0d l=%b exp v=1 a=%0d ts=0 l=%b", i, aer_valid, aer_addr, aer_ts, aer_last, exp_addr[i], (i == 2));
            end
            step();
        end
        checks++; if (aer_valid !== 1'b0 || step_done !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_done got v=%b sd=%b rdy=%b exp v=0 sd=1 rdy=1", aer_valid, step_done, in_ready); end
        step();
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", step_done); end
    endtask

    // Zero vector (stamped 1): no event, step_done next clock. Then {40}
    // must carry ts=2, showing the counter moved past the empty step.
    task automatic test_zero();
        in_spikes = '0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (aer_valid !== 1'b0 || step_done !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_vec got v=%b sd=%b rdy=%b exp v=0 sd=1 rdy=1", aer_valid, step_done, in_ready); end
        step();
        checks++; if (step_done !== 1'b0 || aer_valid !== 1'b0) begin errors++; $display("FAIL zero_after got sd=%b v=%b exp sd=0 v=0", step_done, aer_valid); end
        in_spikes[40] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 7'd40 || aer_ts !== 16'd2 || aer_last !== 1'b1) begin errors++; $display("FAIL zero_next_ts got v=%b a=%0d ts=%0d l=%b exp v=1 a=40 ts=2 l=1", aer_valid, aer_addr, aer_ts, aer_last); end
        step();
        checks++; if (step_done !== 1'b1) begin errors++; $display("FAIL zero_next_done got=%b exp=1", step_done); end
    endtask

    // {5,6} held off for 4 clocks, then drained. A vector arriving with the
    // final handshake is dropped.
    task automatic test_backpressure();
        aer_ready = 1'b0;
        in_spikes = '0;
        in_spikes[5] = 1'b1; in_spikes[6] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aer_valid !== 1'b1 || aer_addr !== 7'd5 || aer_ts !== 16'd3 || aer_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b a=%0d ts=%0d l=%b exp v=1 a=5 ts=3 l=0", i, aer_valid, aer_addr, aer_ts, aer_last);
            end
            step();
        end
        aer_ready = 1'b1;
        checks++; if (aer_addr !== 7'd5 || aer_valid !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b a=%0d exp v=1 a=5", aer_valid, aer_addr); end
        step();
        checks++; if (aer_addr !== 7'd6 || aer_last !== 1'b1 || aer_ts !== 16'd3) begin errors++; $display("FAIL bp_second got a=%0d l=%b ts=%0d exp a=6 l=1 ts=3", aer_addr, aer_last, aer_ts); end
        in_spikes[1] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (aer_valid !== 1'b0 || step_done !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_final_drop_state got v=%b sd=%b rdy=%b exp v=0 sd=1 rdy=1", aer_valid, step_done, in_ready); end
        checks++; if (ovf !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_final_drop_cnt got ovf=%b cnt=%0d exp ovf=1 cnt=1", ovf, drop_cnt); end
        step();
    endtask

    // After reset: all 96 bits with two strobes during SCAN; next vector ts=3.
    task automatic test_full();
        int bad;
        do_reset();
        bad = 0;
        in_spikes = '1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        for (int i = 0; i < 96; i++) begin
            if (aer_valid !== 1'b1 || aer_addr !== AW'(i) || aer_ts !== 16'd0 || aer_last !== (i == 95)) begin
                if (bad == 0) $display("FAIL full_event%0d got v=%b a=%0d ts=%0d l=%b exp v=1 a=%0d ts=0 l=%b", i, aer_valid, aer_addr, aer_ts, aer_last, i, (i == 95));
                bad++;
            end
            in_valid = (i == 10 || i == 11);
            in_spikes = in_valid ? {N{1'b1}} : '0;
            step();
        end
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_sequence got bad_events=%0d exp 0", bad); end
        checks++; if (step_done !== 1'b1 || aer_valid !== 1'b0) begin errors++; $display("FAIL full_done got sd=%b v=%b exp sd=1 v=0", step_done, aer_valid); end
        checks++; if (drop_cnt !== 16'd2 || ovf !== 1'b1) begin errors++; $display("FAIL full_drops got cnt=%0d ovf=%b exp cnt=2 ovf=1", drop_cnt, ovf); end
        in_spikes[2] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (aer_addr !== 7'd2 || aer_ts !== 16'd3 || aer_last !== 1'b1) begin errors++; $display("FAIL full_next_ts got a=%0d ts=%0d l=%b exp a=2 ts=3 l=1", aer_addr, aer_ts, aer_last); end
        step();
    endtask

    // Drop counter saturation, clear, and clear colliding with a drop.
    task automatic test_saturation();
        aer_ready = 1'b0;
        in_spikes = '0;
        in_spikes[0] = 1'b1; in_spikes[1] = 1'b1;
        in_valid = 1'b1;
        step();
        // drop_cnt starts at 2; 65540 drops overshoot 65535.
        for (int i = 0; i < 65540; i++) begin
            step();
        end
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (drop_cnt !== 16'hFFFF || ovf !== 1'b1) begin errors++; $display("FAIL sat_cnt got cnt=%0d ovf=%b exp cnt=65535 ovf=1", drop_cnt, ovf); end
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 7'd0) begin errors++; $display("FAIL sat_scan_hold got v=%b a=%0d exp v=1 a=0", aer_valid, aer_addr); end
        clr_ovf = 1'b1;
        step();
        checks++; if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_only got ovf=%b cnt=%0d exp ovf=0 cnt=0", ovf, drop_cnt); end
        in_valid = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b0 || drop_cnt !== 16'd1) begin errors++; $display("FAIL clr_with_drop got ovf=%b cnt=%0d exp ovf=0 cnt=1", ovf, drop_cnt); end
        step();
        in_valid = 1'b0;
        checks++; if (ovf !== 1'b1 || drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_after_clr got ovf=%b cnt=%0d exp ovf=1 cnt=2", ovf, drop_cnt); end
        aer_ready = 1'b1;
        step();
        checks++; if (aer_addr !== 7'd1 || aer_last !== 1'b1) begin errors++; $display("FAIL sat_drain got a=%0d l=%b exp a=1 l=1", aer_addr, aer_last); end
        step();
    endtask

    // Reset during SCAN of {0..10} after 3 events; ts restarts at 0.
    task automatic test_reset_mid_scan();
        aer_ready = 1'b1;
        in_spikes = '0;
        for (int i = 0; i <= 10; i++) in_spikes[i] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (aer_addr !== AW'(i) || aer_valid !== 1'b1) begin errors++; $display("FAIL mid_event%0d got v=%b a=%0d exp v=1 a=%0d", i, aer_valid, aer_addr, i); end
            step();
        end
        rstn = 1'b0;
        #1;
        checks++; if (aer_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_async got v=%b rdy=%b exp v=0 rdy=1", aer_valid, in_ready); end
        step();
        checks++; if (aer_valid !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_hold got v=%b ovf=%b cnt=%0d exp v=0 ovf=0 cnt=0", aer_valid, ovf, drop_cnt); end
        rstn = 1'b1;
        step();
        checks++; if (aer_valid !== 1'b0 || step_done !== 1'b0) begin errors++; $display("FAIL mid_post_rst got v=%b sd=%b exp v=0 sd=0", aer_valid, step_done); end
        in_spikes[7] = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_spikes = '0;
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 7'd7 || aer_ts !== 16'd0 || aer_last !== 1'b1) begin errors++; $display("FAIL mid_new_vec got v=%b a=%0d ts=%0d l=%b exp v=1 a=7 ts=0 l=1", aer_valid, aer_addr, aer_ts, aer_last); end
        step();
        checks++; if (step_done !== 1'b1 || aer_valid !== 1'b0) begin errors++; $display("FAIL mid_new_done got sd=%b v=%b exp sd=1 v=0", step_done, aer_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_full();
        test_saturation();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
